vga_digit_text_buffer: RTL and testbench
========================================

Name: vga_digit_text_buffer

Overview:
- Character-cell store that feeds the 800x600 digit renderer. It holds one 4-bit digit code per 32x32-pixel cell.
- A host side fills it through a valid/ready write port. An auto-advancing cursor selects the target cell.
- The renderer side presents a cell column/row and receives the stored code one cycle later. The renderer drives the digit glyph ROM with that code.
- A clear engine fills every cell with the blank code, after reset and on command.

Parameters:
- COLS, 25, cells per row (800/32).
- ROWS, 18, cell rows (floor(600/32)).
- BLANK_CODE, 4'hF, code written by clear. Codes 10..15 all render blank.

Ports:
- i_clk  in  1  pixel clock (40 MHz domain); all logic on posedge.
- i_rst  in  1  asynchronous active-high reset.
- i_wr_valid  in  1  host write request.
- i_wr_data  in  4  digit code to store at the cursor.
- o_wr_ready  out  1  registered; high only in IDLE.
- i_cmd_home  in  1  single-cycle pulse: cursor to (0,0).
- i_cmd_clear  in  1  single-cycle pulse: start the clear sweep.
- o_busy  out  1  registered; high while in CLEAR.
- o_cur_col  out  5  current cursor column.
- o_cur_row  out  5  current cursor row.
- i_rd_col  in  5  renderer cell column (horz_pos[9:5] of visible x).
- i_rd_row  in  5  renderer cell row (vert_pos[9:5] of visible y).
- o_rd_digit  out  4  registered code for the cell presented on the previous cycle.
- o_rd_blank  out  1  registered; 1 when the renderer must draw nothing.

Behaviour:
- Storage: COLS*ROWS x 4-bit array. Linear address = row*COLS+col. Keep the col/row counters and the linear address counter in step; no multiplier on the write path.
- Reset (async assert, sync release):
  - state=CLEAR, clear address=0, cursor=(0,0).
  - o_wr_ready=0, o_busy=1, o_rd_digit=BLANK_CODE, o_rd_blank=1.
- FSM state CLEAR: writes BLANK_CODE to one cell per cycle, ascending from address 0.
  - After writing address COLS*ROWS-1, go to IDLE next cycle. o_busy falls and o_wr_ready rises together.
  - A full sweep therefore takes COLS*ROWS cycles (450 at defaults).
  - Cursor is held at (0,0).
  - i_wr_valid and i_cmd_home are ignored.
  - i_cmd_clear restarts the sweep from address 0.
- FSM state IDLE:
  - Handshake = i_wr_valid & o_wr_ready. It stores i_wr_data at the cursor, then advances the cursor.
  - Cursor advance: col+1. At col==COLS-1 the column goes to 0 and row+1. At (COLS-1, ROWS-1) the cursor wraps to (0,0). No scrolling.
  - Back-to-back writes sustain one per cycle.
- Priority in IDLE when events coincide: clear > home > write.
  - Write with clear in the same cycle: the write is accepted and stored. Cursor goes to (0,0) and state goes to CLEAR, so the written cell is overwritten by the sweep.
  - Write with home in the same cycle: the data is stored at the old cursor. The cursor goes to (0,0), not old+1.
- Read path: latency exactly 1 cycle, independent of FSM state.
  - If i_rd_col>=COLS or i_rd_row>=ROWS: o_rd_digit=BLANK_CODE, o_rd_blank=1.
  - Otherwise o_rd_digit = stored code, and o_rd_blank = (state==CLEAR) | (code>9).
  - Read and write to the same cell in the same cycle: the read returns the old value (read-before-write). The new value is visible on a read one cycle later.
- Arithmetic:
  - Counters are 5-bit and compare with ==, so no overflow past COLS-1/ROWS-1.
  - The linear address is wide enough for COLS*ROWS-1 (9 bits at defaults).
- Reset mid-operation: asserting reset mid-sweep or mid-write restarts CLEAR from 0. Any write accepted before the reset is lost.

Test Plan:
- Reset release, no host traffic.
  - o_busy=1 for 450 cycles, then o_busy=0 and o_wr_ready=1.
  - Reading every (c,r) afterwards gives o_rd_digit=4'hF, o_rd_blank=1.
- After clear, write 0..9 repeating for 30 writes.
  - Cursor ends at (5,1).
  - Read (24,0)=4, (0,1)=5, (4,1)=9 with o_rd_blank=0, each one cycle after the address is presented.
- 450 back-to-back writes.
  - Cursor wraps to (0,0).
  - The 451st write, data 7, lands at (0,0).
- Read (25,0) and (0,18) -> o_rd_digit=4'hF, o_rd_blank=1.
- Same-cycle read and write at (3,0), old 1, new 8 -> next-cycle read shows 1; following read shows 8.
- Write with i_cmd_clear in the same cycle at cursor (10,2) -> o_busy=1 for 450 cycles; (10,2) reads 4'hF; cursor=(0,0).
- Write with i_cmd_home in the same cycle at cursor (10,2) -> (10,2) holds the data; cursor=(0,0).
- Assert i_rst at sweep address 200 -> o_wr_ready=0 immediately; a full 450-cycle sweep follows release.

Source files
------------

// File: rtl/vga_digit_text_buffer.sv
// Character-cell store for the 800x600 digit renderer: host write port with an
// auto-advancing cursor, a 1-cycle renderer read port and a blanking clear sweep.
module vga_digit_text_buffer #(
  parameter int          COLS       = 25,
  parameter int          ROWS       = 18,
  parameter logic [3:0]  BLANK_CODE = 4'hF
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_wr_valid,
  input  logic [3:0] i_wr_data,
  output logic       o_wr_ready,
  input  logic       i_cmd_home,
  input  logic       i_cmd_clear,
  output logic       o_busy,
  output logic [4:0] o_cur_col,
  output logic [4:0] o_cur_row,
  input  logic [4:0] i_rd_col,
  input  logic [4:0] i_rd_row,
  output logic [3:0] o_rd_digit,
  output logic       o_rd_blank
);

  localparam int                CELLS     = COLS * ROWS;
  localparam int                ADDR_W    = $clog2(CELLS);
  localparam logic [4:0]        LAST_COL  = 5'(COLS - 1);
  localparam logic [4:0]        LAST_ROW  = 5'(ROWS - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(CELLS - 1);

  typedef enum logic {ST_CLEAR, ST_IDLE} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] clr_addr_q;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic [4:0]        cur_col_q, cur_col_d;
  logic [4:0]        cur_row_q, cur_row_d;
  logic              wr_ready_q;
  logic              busy_q;
  logic [3:0]        rd_digit_q;
  logic              rd_blank_q;

  logic [3:0]        mem [CELLS];

  logic              wr_fire;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [3:0]        mem_wdata;
  logic              rd_in_range;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_code;

  assign wr_fire = i_wr_valid & wr_ready_q;

  // Cursor advance keeps the linear address in step with (col,row).
  always_comb begin
    cur_col_d  = cur_col_q + 5'd1;
    cur_row_d  = cur_row_q;
    cur_addr_d = cur_addr_q + ADDR_W'(1);
    if (cur_col_q == LAST_COL) begin
      cur_col_d = '0;
      if (cur_row_q == LAST_ROW) begin
        cur_row_d  = '0;
        cur_addr_d = '0;
      end else begin
        cur_row_d = cur_row_q + 5'd1;
      end
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = cur_addr_q;
    mem_wdata = i_wr_data;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = BLANK_CODE;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= ST_CLEAR;
      clr_addr_q <= '0;
      cur_addr_q <= '0;
      cur_col_q  <= '0;
      cur_row_q  <= '0;
      wr_ready_q <= 1'b0;
      busy_q     <= 1'b1;
    end else begin
      case (state_q)
        ST_CLEAR: begin
          if (i_cmd_clear) begin
            clr_addr_q <= '0;
          end else if (clr_addr_q == LAST_ADDR) begin
            state_q    <= ST_IDLE;
            wr_ready_q <= 1'b1;
            busy_q     <= 1'b0;
          end else begin
            clr_addr_q <= clr_addr_q + ADDR_W'(1);
          end
        end
        default: begin
          // Clear beats home beats write; a coincident write is still stored.
          if (i_cmd_clear) begin
            state_q    <= ST_CLEAR;
            clr_addr_q <= '0;
            cur_addr_q <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
            wr_ready_q <= 1'b0;
            busy_q     <= 1'b1;
          end else if (i_cmd_home) begin
            cur_addr_q <= '0;
            cur_col_q  <= '0;
            cur_row_q  <= '0;
          end else if (wr_fire) begin
            cur_addr_q <= cur_addr_d;
            cur_col_q  <= cur_col_d;
            cur_row_q  <= cur_row_d;
          end
        end
      endcase
    end
  end

  assign rd_in_range = (int'(i_rd_col) < COLS) && (int'(i_rd_row) < ROWS);
  assign rd_addr     = rd_in_range ? ADDR_W'(int'(i_rd_row) * COLS + int'(i_rd_col)) : '0;
  assign rd_code     = mem[rd_addr];

  // Read is registered against the pre-write array contents (read-before-write).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rd_digit_q <= BLANK_CODE;
      rd_blank_q <= 1'b1;
    end else if (rd_in_range) begin
      rd_digit_q <= rd_code;
      rd_blank_q <= (state_q == ST_CLEAR) | (rd_code > 4'd9);
    end else begin
      rd_digit_q <= BLANK_CODE;
      rd_blank_q <= 1'b1;
    end
  end

  assign o_wr_ready = wr_ready_q;
  assign o_busy     = busy_q;
  assign o_cur_col  = cur_col_q;
  assign o_cur_row  = cur_row_q;
  assign o_rd_digit = rd_digit_q;
  assign o_rd_blank = rd_blank_q;

endmodule

// File: tb/tb_vga_digit_text_buffer.sv
// Directed bench for vga_digit_text_buffer: clear sweep, cursor, priorities,
// read latency/boundaries and reset behaviour.
module tb_vga_digit_text_buffer;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       cmd_home;
  logic       cmd_clear;
  logic       busy;
  logic [4:0] cur_col, cur_row;
  logic [4:0] rd_col, rd_row;
  logic [3:0] rd_digit;
  logic       rd_blank;

  int total  = 0;
  int passed = 0;

  vga_digit_text_buffer dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .i_wr_data   (wr_data),
    .o_wr_ready  (wr_ready),
    .i_cmd_home  (cmd_home),
    .i_cmd_clear (cmd_clear),
    .o_busy      (busy),
    .o_cur_col   (cur_col),
    .o_cur_row   (cur_row),
    .i_rd_col    (rd_col),
    .i_rd_row    (rd_row),
    .o_rd_digit  (rd_digit),
    .o_rd_blank  (rd_blank)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_cursor(input string tag, input int c, input int r);
    check({tag, "_col"}, 32'(cur_col), c);
    check({tag, "_row"}, 32'(cur_row), r);
  endtask

  task automatic read_cell(input string tag, input int c, input int r,
                           input logic [3:0] d, input logic b);
    rd_col = 5'(c);
    rd_row = 5'(r);
    @(negedge clk);
    check({tag, "_digit"}, 32'(rd_digit), 32'(d));
    check({tag, "_blank"}, 32'(rd_blank), 32'(b));
  endtask

  task automatic write1(input logic [3:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic write_run(input int n, input logic [3:0] d);
    for (int i = 0; i < n; i++) write1(d);
  endtask

  // Called on a negedge where busy is expected high; counts busy samples.
  task automatic wait_sweep(input string tag);
    int cnt = 0;
    while (busy === 1'b1 && cnt < 1000) begin
      cnt++;
      @(negedge clk);
    end
    check(tag, cnt, 450);
    check({tag, "_ready"}, 32'(wr_ready), 1);
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0; cmd_home = 1'b0; cmd_clear = 1'b0;
    rd_col = '0; rd_row = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(wr_ready), 0);
    check("rst_busy", 32'(busy), 1);
    check("rst_digit", 32'(rd_digit), 32'hF);
    check("rst_blank", 32'(rd_blank), 1);
    check_cursor("rst_cur", 0, 0);

    // Power-up sweep and fully blank array.
    rst = 1'b0;
    wait_sweep("init_sweep");
    check("init_busy_low", 32'(busy), 0);
    for (int r = 0; r < 18; r++) begin
      for (int c = 0; c < 25; c++) begin
        rd_col = 5'(c);
        rd_row = 5'(r);
        @(negedge clk);
        check("blank_all", {27'd0, rd_digit, rd_blank}, 32'h1F);
      end
    end

    // 30 writes of 0..9 repeating.
    for (int i = 0; i < 30; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'(i % 10);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check_cursor("w30_cur", 5, 1);
    read_cell("rd_24_0", 24, 0, 4'd4, 1'b0);
    read_cell("rd_0_1", 0, 1, 4'd5, 1'b0);
    read_cell("rd_4_1", 4, 1, 4'd9, 1'b0);

    // Home, then 450 back-to-back writes of (addr+8)%10.
    cmd_home = 1'b1;
    @(negedge clk);
    cmd_home = 1'b0;
    check_cursor("home_cur", 0, 0);
    for (int i = 0; i < 450; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'((i + 8) % 10);
      @(negedge clk);
    end
    wr_valid = 1'b0;
    check_cursor("wrap_cur", 0, 0);
    read_cell("rd_24_17", 24, 17, 4'd7, 1'b0);
    read_cell("rd_23_17", 23, 17, 4'd6, 1'b0);
    write1(4'd7);
    check_cursor("w451_cur", 1, 0);
    read_cell("rd_0_0_w451", 0, 0, 4'd7, 1'b0);

    // Out-of-range reads.
    read_cell("oor_25_0", 25, 0, 4'hF, 1'b1);
    read_cell("oor_0_18", 0, 18, 4'hF, 1'b1);
    read_cell("oor_31_31", 31, 31, 4'hF, 1'b1);

    // Same-cycle read and write at (3,0): old 1, new 8.
    write1(4'd5);
    write1(4'd6);
    check_cursor("pre_rbw_cur", 3, 0);
    rd_col = 5'd3; rd_row = 5'd0;
    wr_valid = 1'b1; wr_data = 4'd8;
    @(negedge clk);
    wr_valid = 1'b0;
    check("rbw_old", 32'(rd_digit), 1);
    @(negedge clk);
    check("rbw_new", 32'(rd_digit), 8);
    check("rbw_new_blank", 32'(rd_blank), 0);

    // Write with home at (10,2).
    cmd_home = 1'b1;
    @(negedge clk);
    cmd_home = 1'b0;
    write_run(60, 4'd2);
    check_cursor("pre_home_cur", 10, 2);
    wr_valid = 1'b1; wr_data = 4'hB; cmd_home = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; cmd_home = 1'b0;
    check_cursor("wr_home_cur", 0, 0);
    read_cell("wr_home_cell", 10, 2, 4'hB, 1'b1);
    read_cell("wr_home_next", 11, 2, 4'd9, 1'b0);
    read_cell("wr_home_prev", 9, 2, 4'd2, 1'b0);

    // Write with clear at (10,2).
    write_run(60, 4'd2);
    check_cursor("pre_clr_cur", 10, 2);
    wr_valid = 1'b1; wr_data = 4'd3; cmd_clear = 1'b1;
    @(negedge clk);
    wr_valid = 1'b0; cmd_clear = 1'b0;
    check("clr_busy", 32'(busy), 1);
    check("clr_ready", 32'(wr_ready), 0);
    check_cursor("clr_cur", 0, 0);
    rd_col = 5'd11; rd_row = 5'd2;
    begin
      int cnt = 0;
      while (busy === 1'b1 && cnt < 1000) begin
        cnt++;
        @(negedge clk);
        if (cnt == 1) begin
          check("in_sweep_digit", 32'(rd_digit), 9);
          check("in_sweep_blank", 32'(rd_blank), 1);
        end
      end
      check("clr_sweep", cnt, 450);
    end
    check("clr_ready_after", 32'(wr_ready), 1);
    read_cell("clr_cell", 10, 2, 4'hF, 1'b1);
    check_cursor("clr_cur_after", 0, 0);

    // Reset at sweep address 200.
    write1(4'd4);
    cmd_clear = 1'b1;
    @(negedge clk);
    cmd_clear = 1'b0;
    repeat (199) @(negedge clk);
    read_cell("mid_sweep", 20, 10, 4'hF, 1'b1);
    write_run(0, 4'd0);
    rd_col = 5'd20; rd_row = 5'd10;
    rst = 1'b1;
    #1;
    check("rst200_ready", 32'(wr_ready), 0);
    check("rst200_busy", 32'(busy), 1);
    check("rst200_digit", 32'(rd_digit), 32'hF);
    @(negedge clk);
    rst = 1'b0;
    wait_sweep("rst200_sweep");

    // Reset in the middle of an IDLE write.
    write1(4'd6);
    read_cell("pre_rst_wr", 0, 0, 4'd6, 1'b0);
    check_cursor("pre_rst_cur", 1, 0);
    wr_valid = 1'b1; wr_data = 4'd5;
    #2;
    rst = 1'b1;
    #1;
    check("rst_idle_ready", 32'(wr_ready), 0);
    check("rst_idle_busy", 32'(busy), 1);
    check_cursor("rst_idle_cur", 0, 0);
    check("rst_idle_digit", 32'(rd_digit), 32'hF);
    @(negedge clk);
    wr_valid = 1'b0;
    rst = 1'b0;
    wait_sweep("rst_idle_sweep");
    read_cell("lost_write", 0, 0, 4'hF, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
